mem_stage: RTL and testbench
============================

// Module: mem_stage
//
// PURPOSE
//  - Memory-access stage between execute (ALU) and register-file writeback.
//  - Accepts one op per handshake from execute and runs loads/stores against a
//    multicycle req/ack data memory.
//  - Builds byte enables and store lane data; extracts and sign/zero-extends load data.
//  - Returns a registered writeback packet (rd, wren, data) for every accepted op.
//
// PARAMETERS
//  AWIDTH   32  address width
//  DWIDTH   32  data width; design fixed at 32 (4 byte lanes)
//
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active-low
//  valid_i        in   1       execute presents an op
//  ready_o        out  1       stage can accept (state==IDLE)
//  addr_i         in   AWIDTH  ALU result (effective address / passthrough)
//  wdata_i        in   DWIDTH  rs2 store data
//  funct3_i       in   3       LB/LH/LW/LBU/LHU or SB/SH/SW encoding
//  memren_i       in   1       op is a load
//  memwren_i      in   1       op is a store
//  rd_i           in   5       destination register
//  regwren_i      in   1       op writes rd
//  wbdata_i       in   DWIDTH  non-load writeback value (ALU/PC+4/IMM, selected upstream)
//  dmem_req_o     out  1       memory request, held until ack
//  dmem_we_o      out  1       1=write
//  dmem_addr_o    out  AWIDTH  word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o      out  4       byte enables (writes); 4'hF on reads
//  dmem_wdata_o   out  DWIDTH  lane-replicated store data
//  dmem_ack_i     in   1       memory done; rdata valid same cycle for reads
//  dmem_rdata_i   in   DWIDTH  read word
//  wb_valid_o     out  1       one-cycle pulse per completed op
//  wb_rd_o        out  5       writeback rd
//  wb_regwren_o   out  1       regwren_i & ~memwren_i & (rd_i!=0), and not faulted
//  wb_data_o      out  DWIDTH  load result or wbdata_i
//  misalign_o     out  1       fault flag, valid with wb_valid_o
//  fault_addr_o   out  AWIDTH  faulting byte address
//
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, except ready_o=1 after deassertion.
//    Async assert mid-transaction drops dmem_req_o immediately and discards the op.
//  - FSM IDLE -> (valid_i & ready_o)
//      - non-mem op -> RESP
//      - mem op -> REQ, or RESP when faulted
//  - FSM REQ -> (dmem_ack_i) -> RESP; capture rdata. RESP -> IDLE; wb_valid_o=1.
//  - Op fields are latched at accept; inputs are ignored outside IDLE.
//  - Latency:
//      - non-mem: accept at N, wb_valid at N+1.
//      - mem: req high from N+1; ack at M>=N+1; wb_valid at M+1.
//      - Back-to-back non-mem ops: one accept every 2 cycles.
//  - dmem_req_o/we/addr/be/wdata are stable from REQ entry until ack. An ack with req low is ignored.
//  - memren_i & memwren_i both set: treated as store.
//  - Store lanes (a=addr[1:0]):
//      - SB: be=1<<a, wdata={4{b}}
//      - SH: be=a[1]?4'hC:4'h3, wdata={2{h}}
//      - SW: 4'hF
//  - Load: select byte a / half a[1] of rdata.
//      - LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
//      - Unused funct3 values (3,6,7) load as LW; store funct3>2 acts as SW.
//  - Misaligned: LH/LHU/SH with a[0]=1; LW/SW with a!=0.
//
// CONFIGURATION
//  MEM_STAGE_MISALIGN_TRAP_EN defined:
//    - misaligned op issues no dmem request and goes IDLE->RESP.
//    - misalign_o=1, fault_addr_o=addr_i, wb_regwren_o=0 in that RESP cycle.
//  Undefined:
//    - low address bits truncated to natural alignment (half: a[0]=0; word: a=0); access proceeds.
//    - misalign_o and fault_addr_o tied 0.
//
// TESTING
//  - SW addr=0x104 data=0xDEADBEEF, ack 3 cycles later -> be=F, addr=0x104, req held 3 cycles, wb_regwren_o=0.
//  - SB addr=0x103 data=0x000000A5 -> be=4'h8, wdata=0xA5A5A5A5.
//  - LB addr=0x102 rdata=0x0080FF00 rd=5 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
//  - ADD passthrough wbdata=0x1234 rd=0 -> wb_valid at N+1, no req, wb_regwren_o=0.
//  - LW addr=0x106: with MEM_STAGE_MISALIGN_TRAP_EN -> no req, misalign_o=1, fault_addr=0x106.
//    Without it -> req addr=0x104.
//  - rst low while in REQ -> req drops same cycle; late ack ignored; next op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage sitting between execute and register-file writeback.
// It accepts one op per valid/ready handshake, runs loads and stores against
// a multicycle req/ack data memory, and returns one registered writeback
// packet per accepted op.
//
// Configuration macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : misaligned loads/stores issue no memory request and complete
//               immediately with misalign_o=1 and fault_addr_o=byte address.
//   undefined : low address bits are truncated to natural alignment and the
//               access proceeds; misalign_o and fault_addr_o are tied to 0.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   valid_i        execute presents an op
//   ready_o        stage can accept an op (idle)
//   addr_i         ALU result: effective address or passthrough
//   wdata_i        store data (rs2)
//   funct3_i       load/store width and signedness
//   memren_i       op is a load
//   memwren_i      op is a store (wins if memren_i is also set)
//   rd_i           destination register
//   regwren_i      op writes rd
//   wbdata_i       non-load writeback value
//   dmem_req_o     memory request, held until dmem_ack_i
//   dmem_we_o      1 = write
//   dmem_addr_o    word-aligned address
//   dmem_be_o      byte enables (4'hF on reads)
//   dmem_wdata_o   lane-replicated store data
//   dmem_ack_i     memory done; read data valid in the same cycle
//   dmem_rdata_i   read word
//   wb_valid_o     one-cycle pulse per completed op
//   wb_rd_o        writeback destination register
//   wb_regwren_o   writeback register write enable
//   wb_data_o      load result or wbdata_i
//   misalign_o     fault flag, valid with wb_valid_o
//   fault_addr_o   faulting byte address, valid with wb_valid_o
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32   // lane logic below assumes 32 (4 byte lanes)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic [2:0]        funct3_i,
   input  logic              memren_i,
   input  logic              memwren_i,
   input  logic [4:0]        rd_i,
   input  logic              regwren_i,
   input  logic [DWIDTH-1:0] wbdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [AWIDTH-1:0] dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [DWIDTH-1:0] dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [DWIDTH-1:0] dmem_rdata_i,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic              wb_regwren_o,
   output logic [DWIDTH-1:0] wb_data_o,
   output logic              misalign_o,
   output logic [AWIDTH-1:0] fault_addr_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // ---------------------------------------------------------------- state
   state_t            r_state;
   logic              r_ready;

   // op fields latched at accept
   logic [2:0]        r_funct3;
   logic [1:0]        r_lo;
   logic              r_is_load;
   logic [4:0]        r_rd;
   logic              r_op_regwren;
   logic [DWIDTH-1:0] r_wbdata;

   // memory request
   logic              r_req;
   logic              r_we;
   logic [AWIDTH-1:0] r_addr;
   logic [3:0]        r_be;
   logic [DWIDTH-1:0] r_wdata;

   // writeback packet
   logic              r_wb_valid;
   logic [4:0]        r_wb_rd;
   logic              r_wb_regwren;
   logic [DWIDTH-1:0] r_wb_data;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic              r_misalign;
   logic [AWIDTH-1:0] r_fault_addr;
`endif

   // ------------------------------------------------- accept-side decode
   logic              w_is_mem;
   logic              w_is_store;
   logic              w_is_load;
   logic [1:0]        w_lo;
   logic [1:0]        w_size;
   logic [1:0]        w_lo_eff;
   logic              w_fault;
   logic [3:0]        w_be;
   logic [DWIDTH-1:0] w_st_wdata;
   logic              w_wb_regwren;

   assign w_is_store = memwren_i;
   assign w_is_load  = memren_i & ~memwren_i;
   assign w_is_mem   = memren_i | memwren_i;
   assign w_lo       = addr_i[1:0];

   // Access size; unused load encodings and store encodings above SW
   // both fall through to a full word.
   always_comb begin
      w_size = SZ_WORD;
      if (w_is_load) begin
         case (funct3_i)
            3'd0, 3'd4: w_size = SZ_BYTE;
            3'd1, 3'd5: w_size = SZ_HALF;
            default:    w_size = SZ_WORD;
         endcase
      end else begin
         case (funct3_i)
            3'd0:    w_size = SZ_BYTE;
            3'd1:    w_size = SZ_HALF;
            default: w_size = SZ_WORD;
         endcase
      end
   end

   // Natural-alignment truncation. When the trap is enabled, any op that
   // would be truncated faults instead, so this is a no-op for the ops
   // that actually reach memory.
   always_comb begin
      case (w_size)
         SZ_BYTE: w_lo_eff = w_lo;
         SZ_HALF: w_lo_eff = {w_lo[1], 1'b0};
         default: w_lo_eff = 2'b00;
      endcase
   end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = ((w_size == SZ_HALF) & w_lo[0]) |
                         ((w_size == SZ_WORD) & (w_lo != 2'b00));
   assign w_fault      = w_is_mem & w_misaligned;
`else
   assign w_fault      = 1'b0;
`endif

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be       = 4'hF;
      w_st_wdata = '0;
      if (w_is_store) begin
         case (w_size)
            SZ_BYTE: begin
               w_be       = 4'b0001 << w_lo_eff;
               w_st_wdata = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
               w_be       = w_lo_eff[1] ? 4'hC : 4'h3;
               w_st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
               w_be       = 4'hF;
               w_st_wdata = wdata_i;
            end
         endcase
      end
   end

   assign w_wb_regwren = regwren_i & ~memwren_i & (rd_i != 5'd0) & ~w_fault;

   // -------------------------------------------------- load extraction
   logic [7:0]        w_lane [0:3];
   logic [7:0]        w_ld_byte;
   logic [15:0]       w_ld_half;
   logic [DWIDTH-1:0] w_ld_data;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = dmem_rdata_i[8*gi +: 8];
   end

   always_comb begin
      w_ld_byte = w_lane[r_lo];
      w_ld_half = r_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (r_funct3)
         3'd0:    w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'd1:    w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'd4:    w_ld_data = {24'd0, w_ld_byte};
         3'd5:    w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = dmem_rdata_i;
      endcase
   end

   // ------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_ready      <= 1'b0;
         r_funct3     <= '0;
         r_lo         <= '0;
         r_is_load    <= 1'b0;
         r_rd         <= '0;
         r_op_regwren <= 1'b0;
         r_wbdata     <= '0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_be         <= '0;
         r_wdata      <= '0;
         r_wb_valid   <= 1'b0;
         r_wb_rd      <= '0;
         r_wb_regwren <= 1'b0;
         r_wb_data    <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         r_misalign   <= 1'b0;
         r_fault_addr <= '0;
`endif
      end else begin
         // writeback flags are single-cycle pulses
         r_wb_valid   <= 1'b0;
         r_wb_regwren <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         r_misalign   <= 1'b0;
         r_fault_addr <= '0;
`endif
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               if (valid_i && r_ready) begin
                  r_ready      <= 1'b0;
                  r_funct3     <= funct3_i;
                  r_lo         <= w_lo_eff;
                  r_is_load    <= w_is_load;
                  r_rd         <= rd_i;
                  r_op_regwren <= w_wb_regwren;
                  r_wbdata     <= wbdata_i;
                  if (w_is_mem && !w_fault) begin
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                     r_we    <= w_is_store;
                     r_addr  <= {addr_i[AWIDTH-1:2], 2'b00};
                     r_be    <= w_be;
                     r_wdata <= w_st_wdata;
                  end else begin
                     // non-memory op or trapped access: answer directly
                     r_state      <= S_RESP;
                     r_wb_valid   <= 1'b1;
                     r_wb_rd      <= rd_i;
                     r_wb_regwren <= w_wb_regwren;
                     r_wb_data    <= w_fault ? '0 : wbdata_i;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                     r_misalign   <= w_fault;
                     r_fault_addr <= w_fault ? addr_i : '0;
`endif
                  end
               end
            end
            S_REQ: begin
               if (dmem_ack_i) begin
                  r_state      <= S_RESP;
                  r_req        <= 1'b0;
                  r_we         <= 1'b0;
                  r_wb_valid   <= 1'b1;
                  r_wb_rd      <= r_rd;
                  r_wb_regwren <= r_op_regwren;
                  r_wb_data    <= r_is_load ? w_ld_data : r_wbdata;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------- outputs
   assign ready_o      = r_ready;
   assign dmem_req_o   = r_req;
   assign dmem_we_o    = r_we;
   assign dmem_addr_o  = r_addr;
   assign dmem_be_o    = r_be;
   assign dmem_wdata_o = r_wdata;
   assign wb_valid_o   = r_wb_valid;
   assign wb_rd_o      = r_wb_rd;
   assign wb_regwren_o = r_wb_regwren;
   assign wb_data_o    = r_wb_data;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign misalign_o   = r_misalign;
   assign fault_addr_o = r_fault_addr;
`else
   assign misalign_o   = 1'b0;
   assign fault_addr_o = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Expected writeback packets are queued when an
// op is driven and compared by a monitor whenever wb_valid_o pulses. Memory
// request fields, latencies and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   typedef struct packed {
      logic [4:0]  rd;
      logic        regwren;
      logic [31:0] data;
      logic        data_chk;
      logic        misalign;
      logic [31:0] faddr;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [2:0]  funct3_i = '0;
   logic        memren_i = 1'b0;
   logic        memwren_i = 1'b0;
   logic [4:0]  rd_i = '0;
   logic        regwren_i = 1'b0;
   logic [31:0] wbdata_i = '0;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic        wb_regwren_o;
   logic [31:0] wb_data_o;
   logic        misalign_o;
   logic [31:0] fault_addr_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   wb_t exp_q[$];

   mem_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .ready_o(ready_o),
      .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
      .memren_i(memren_i), .memwren_i(memwren_i),
      .rd_i(rd_i), .regwren_i(regwren_i), .wbdata_i(wbdata_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_regwren_o(wb_regwren_o),
      .wb_data_o(wb_data_o), .misalign_o(misalign_o), .fault_addr_o(fault_addr_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic wb_t mk(input logic [4:0] rd, input logic rw, input logic [31:0] d,
                              input logic mis, input logic [31:0] fa);
      wb_t e;
      e.rd = rd; e.regwren = rw; e.data = d; e.data_chk = ~mis;
      e.misalign = mis; e.faddr = fa;
      return e;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 1, 0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            $display("wb rd=%0d wren=%0b data=%h mis=%0b fa=%h", wb_rd_o, wb_regwren_o,
                     wb_data_o, misalign_o, fault_addr_o);
            chk("wb_rd", wb_rd_o, e.rd);
            chk("wb_regwren", wb_regwren_o, e.regwren);
            if (e.data_chk) chk("wb_data", wb_data_o, e.data);
            chk("wb_misalign", misalign_o, e.misalign);
            chk("wb_fault_addr", fault_addr_o, e.faddr);
         end
      end
   end

   // Drive one op at a negedge once ready; returns at the negedge after accept.
   task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic [4:0] rd,
                       input logic rw, input logic [31:0] wb, input wb_t e,
                       output int acc);
      int n = 0;
      while (ready_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", ready_o, 1);
      addr_i = a; wdata_i = wd; funct3_i = f3; memren_i = mr; memwren_i = mw;
      rd_i = rd; regwren_i = rw; wbdata_i = wb; valid_i = 1'b1;
      exp_q.push_back(e);
      acc = cyc;
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   // Service a pending request: req must be high and stable for 'delay' cycles,
   // ack in the last, then wb_valid must follow in the next cycle.
   task automatic serve(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int delay, input logic [31:0] rdata);
      int held = 0;
      for (int i = 0; i < delay; i++) begin
         if (dmem_req_o === 1'b1) held++;
         chk("dmem_we", dmem_we_o, we);
         chk("dmem_addr", dmem_addr_o, a);
         chk("dmem_be", dmem_be_o, be);
         if (we) chk("dmem_wdata", dmem_wdata_o, wd);
         chk("wb_valid_during_req", wb_valid_o, 0);
         if (i == delay - 1) begin
            dmem_ack_i = 1'b1;
            dmem_rdata_i = rdata;
         end
         @(negedge clk);
      end
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'hBAD0_BAD0;
      $display("mem we=%0b addr=%h be=%h wdata=%h held=%0d", we, a, be, wd, held);
      chk("req_held_cycles", held, delay);
      chk("req_drop_after_ack", dmem_req_o, 0);
      chk("wb_valid_after_ack", wb_valid_o, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int a0, a1;

      // ---------------- reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready_o, 0);
      chk("rst_req", dmem_req_o, 0);
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_be", dmem_be_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      chk("rst_misalign", misalign_o, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", ready_o, 1);

      // ---------------- SW 0x104, ack 3 cycles later; inputs wiggled during REQ
      send(32'h104, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, 5'd7, 1'b1, 32'h55,
           mk(5'd7, 1'b0, 32'h55, 1'b0, 32'h0), a0);
      valid_i = 1'b1; addr_i = 32'h900; memwren_i = 1'b0; wbdata_i = 32'h77;
      serve(1'b1, 32'h104, 4'hF, 32'hDEADBEEF, 3, 32'h0);
      valid_i = 1'b0;
      chk("ready_in_resp", ready_o, 0);

      // ---------------- SB 0x103 / SH 0x102
      send(32'h103, 32'h000000A5, 3'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,
           mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0), a0);
      serve(1'b1, 32'h100, 4'h8, 32'hA5A5A5A5, 1, 32'h0);
      send(32'h102, 32'h1234BEEF, 3'd1, 1'b0, 1'b1, 5'd2, 1'b0, 32'h0,
           mk(5'd2, 1'b0, 32'h0, 1'b0, 32'h0), a0);
      serve(1'b1, 32'h100, 4'hC, 32'hBEEFBEEF, 2, 32'h0);

      // ---------------- loads
      send(32'h102, 32'h0, 3'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'h0,
           mk(5'd5, 1'b1, 32'hFFFFFF80, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h100, 4'hF, 32'h0, 2, 32'h0080FF00);
      send(32'h102, 32'h0, 3'd4, 1'b1, 1'b0, 5'd5, 1'b1, 32'h0,
           mk(5'd5, 1'b1, 32'h00000080, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h100, 4'hF, 32'h0, 1, 32'h0080FF00);
      send(32'h102, 32'h0, 3'd1, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0,
           mk(5'd6, 1'b1, 32'hFFFF8001, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h100, 4'hF, 32'h0, 1, 32'h80010000);
      send(32'h100, 32'h0, 3'd5, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0,
           mk(5'd6, 1'b1, 32'h0000F00D, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h100, 4'hF, 32'h0, 1, 32'h1234F00D);
      send(32'h108, 32'h0, 3'd3, 1'b1, 1'b0, 5'd8, 1'b1, 32'h0,
           mk(5'd8, 1'b1, 32'h89ABCDEF, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h108, 4'hF, 32'h0, 2, 32'h89ABCDEF);

      // ---------------- load+store flags together, funct3=5: acts as SW
      send(32'h10C, 32'h0F0F0F0F, 3'd5, 1'b1, 1'b1, 5'd4, 1'b1, 32'h99,
           mk(5'd4, 1'b0, 32'h99, 1'b0, 32'h0), a0);
      serve(1'b1, 32'h10C, 4'hF, 32'h0F0F0F0F, 1, 32'h0);

      // ---------------- ADD passthrough rd=0, then back-to-back rd=3
      send(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1234,
           mk(5'd0, 1'b0, 32'h1234, 1'b0, 32'h0), a0);
      chk("nonmem_wb_valid_n1", wb_valid_o, 1);
      chk("nonmem_no_req", dmem_req_o, 0);
      chk("nonmem_ready_low", ready_o, 0);
      send(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd3, 1'b1, 32'hCAFE,
           mk(5'd3, 1'b1, 32'hCAFE, 1'b0, 32'h0), a1);
      chk("b2b_accept_spacing", a1 - a0, 2);
      chk("b2b_wb_valid_n1", wb_valid_o, 1);
      $display("b2b accepts at cycles %0d and %0d", a0, a1);

      // ---------------- misaligned LW 0x106 and SH 0x101
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      send(32'h106, 32'h0, 3'd2, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0,
           mk(5'd9, 1'b0, 32'h0, 1'b1, 32'h106), a0);
      chk("trap_lw_no_req", dmem_req_o, 0);
      chk("trap_lw_wb_n1", wb_valid_o, 1);
      send(32'h101, 32'h0000ABCD, 3'd1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,
           mk(5'd0, 1'b0, 32'h0, 1'b1, 32'h101), a0);
      chk("trap_sh_no_req", dmem_req_o, 0);
      chk("trap_sh_wb_n1", wb_valid_o, 1);
`else
      send(32'h106, 32'h0, 3'd2, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0,
           mk(5'd9, 1'b1, 32'h11223344, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h104, 4'hF, 32'h0, 1, 32'h11223344);
      send(32'h101, 32'h0000ABCD, 3'd1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,
           mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0), a0);
      serve(1'b1, 32'h100, 4'h3, 32'hABCDABCD, 1, 32'h0);
`endif

      // ---------------- ack while idle is ignored
      @(negedge clk);
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555AAAA;
      @(negedge clk);
      dmem_ack_i = 1'b0;
      chk("idle_ack_no_wb", wb_valid_o, 0);
      chk("idle_ack_ready", ready_o, 1);

      // ---------------- reset while in REQ, late ack, then normal ops
      send(32'h200, 32'h0, 3'd2, 1'b1, 1'b0, 5'd10, 1'b1, 32'h0,
           mk(5'd10, 1'b1, 32'h0, 1'b0, 32'h0), a0);
      chk("pre_rst_req", dmem_req_o, 1);
      rst = 1'b0;
      #1;
      chk("rst_req_drop", dmem_req_o, 0);
      chk("rst_mid_ready", ready_o, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD0000;
      @(negedge clk);
      dmem_ack_i = 1'b0;
      chk("late_ack_no_req", dmem_req_o, 0);
      chk("late_ack_no_wb", wb_valid_o, 0);
      chk("late_ack_ready", ready_o, 1);
      send(32'h200, 32'h0, 3'd2, 1'b1, 1'b0, 5'd10, 1'b1, 32'h0,
           mk(5'd10, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0), a0);
      serve(1'b0, 32'h200, 4'hF, 32'h0, 2, 32'hCAFEF00D);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
